// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response bus between the prefetch unit (master)
// and instruction memory (slave).
interface if_prefetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front end: credit-limited in-order word fetches feeding a
// small PC-tagged FIFO whose head is presented to the IF/ID register.
module if_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                a_reset_l,
    input  logic                hold_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    if_prefetch_unit_if.master  imem,
    output logic                valid_o,
    output logic [XLEN-1:0]     instr_o,
    output logic [XLEN-1:0]     pc_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic            r_active;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    logic [XLEN-1:0] w_slot_instr [DEPTH];
    logic [XLEN-1:0] w_slot_pc    [DEPTH];

    logic [XLEN-1:0] w_target;
    logic            w_pop;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic [SW-1:0]   w_used;
    logic [SW-1:0]   w_limit;
    logic            w_req;
    logic            w_grant;
    logic [CW-1:0]   w_after_pop;
    logic [CW-1:0]   w_count_next;
    logic [PW-1:0]   w_rd_ptr_next;
    logic [XLEN-1:0] w_instr_next;
    logic [XLEN-1:0] w_pc_next;

    assign w_target = redirect_pc_i & ~XLEN'(3);
    assign w_pop    = (r_count != '0) && !hold_i;
    assign w_rsp    = imem.imem_rvalid && (r_outstanding != '0);
    assign w_drop   = w_rsp && (r_discard != '0);
    assign w_push   = w_rsp && (r_discard == '0) && !redirect_i;

    // A slot being popped this cycle is already free for a response that can
    // only arrive at least one cycle later, which keeps one fetch per cycle.
    assign w_used  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_limit = SW'(DEPTH) + SW'(w_pop);
    assign w_req   = r_active && !redirect_i && (w_used < w_limit);
    assign w_grant = w_req && imem.imem_gnt;

    assign w_after_pop   = r_count - CW'(w_pop);
    assign w_count_next  = redirect_i ? '0 : (w_after_pop + CW'(w_push));
    assign w_rd_ptr_next = redirect_i ? '0 : (r_rd_ptr + PW'(w_pop));

    always_comb begin
        w_instr_next = NOP;
        w_pc_next    = r_pc;
        if (w_count_next == '0) begin
            w_instr_next = NOP;
            w_pc_next    = r_pc;
        end else if (w_after_pop == '0) begin
            // Buffer drains this cycle, so the incoming word becomes the head.
            w_instr_next = imem.imem_rdata;
            w_pc_next    = r_resp_pc;
        end else begin
            w_instr_next = w_slot_instr[w_rd_ptr_next];
            w_pc_next    = w_slot_pc[w_rd_ptr_next];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [XLEN-1:0] r_slot_instr;
            logic [XLEN-1:0] r_slot_pc;

            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_slot_instr <= imem.imem_rdata;
                    r_slot_pc    <= r_resp_pc;
                end
            end

            assign w_slot_instr[gi] = r_slot_instr;
            assign w_slot_pc[gi]    = r_slot_pc;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_valid       <= 1'b0;
            r_instr       <= NOP;
            r_pc          <= '0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
            r_count       <= w_count_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_valid       <= (w_count_next != '0);
            r_instr       <= w_instr_next;
            r_pc          <= w_pc_next;
            if (redirect_i) begin
                // Every fetch still in flight returns a word from the old path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= r_outstanding - CW'(w_rsp);
                r_wr_ptr   <= '0;
            end else begin
                r_fetch_pc <= r_fetch_pc + (w_grant ? XLEN'(4) : XLEN'(0));
                r_resp_pc  <= r_resp_pc + (w_push ? XLEN'(4) : XLEN'(0));
                r_discard  <= r_discard - CW'(w_drop);
                r_wr_ptr   <= r_wr_ptr + PW'(w_push);
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;
    assign valid_o        = r_valid;
    assign instr_o        = r_instr;
    assign pc_o           = r_pc;

    // A response with nothing in flight is a memory protocol error; it is ignored.
    assert property (@(posedge clk) disable iff (!a_reset_l)
        !(imem.imem_rvalid && (r_outstanding == '0)));

endmodule
